// File: rtl/gapbuf_rr_sched_pkg.sv
// gapbuf_rr_sched_pkg: shared state encoding and width helper for the gap-buffer scheduler
package gapbuf_rr_sched_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/gapbuf_rr_sched_arb.sv
// rr_arb_onehot: round-robin pick of the first requester at or after ptr, wrapping to 0
module rr_arb_onehot
  import gapbuf_rr_sched_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CHW = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] win
);
  int idx;
  // Scan from farthest to nearest so the closest requester to ptr wins last.
  always_comb begin
    grant = '0;
    win = '0;
    idx = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NCH;
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        win = idx[CHW-1:0];
      end
    end
  end
endmodule

// File: rtl/gapbuf_rr_sched.sv
// gapbuf_rr_sched: credit-limited round-robin scheduler over NCH gap-buffer request ports
module gapbuf_rr_sched
  import gapbuf_rr_sched_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int INFO = 32,
  parameter int CRD  = 8,
  parameter int CRW  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ienable,
  input  logic [NCH-1:0]      imask,
  input  logic [NCH-1:0]      ch_req,
  input  logic [NCH*INFO-1:0] ch_info,
  output logic [NCH-1:0]      ch_get,
  output logic                ovld,
  output logic [INFO-1:0]     oinfo,
  output logic [CHW-1:0]      ochid,
  input  logic                icrdret,
  output logic [CRW-1:0]      ocredit,
  output logic                obusy,
  output logic                oerr
);
  if (CHW != clog2(NCH) || CRW != clog2(CRD + 1)) begin : g_bad_width
    $error("gapbuf_rr_sched: CHW/CRW inconsistent with NCH/CRD");
  end
  logic [1:0]     state, state_n;
  logic [CHW-1:0] ptr, win;
  logic [NCH-1:0] last_get, elig;
  logic           run, full, grant;
  always_ff @(posedge clk)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  // "In flight" means a word granted last cycle is still on the output.
  always_comb
    state_n = state == ST_IDLE ? (ienable ? ST_RUN : ST_IDLE) :
              state == ST_RUN  ? (ienable ? ST_RUN : ST_DRAIN) :
              ienable          ? ST_RUN :
              (full && !ovld)  ? ST_IDLE : ST_DRAIN;
  always_comb begin
    run = state == ST_RUN;
    obusy = state != ST_IDLE;
  end
  assign full = ocredit == CRW'(CRD);
  // The channel granted last cycle is masked so no channel gets back-to-back grants.
  assign elig = ch_req & imask & ~last_get & {NCH{run && ocredit != '0}};
  assign grant = |ch_get;
  rr_arb_onehot #(.NCH(NCH)) u_arb (
    .req  (elig),
    .ptr  (ptr),
    .grant(ch_get),
    .win  (win)
  );
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= '0;
      last_get <= '0;
      ovld <= 1'b0;
      oinfo <= '0;
      ochid <= '0;
      ocredit <= CRW'(CRD);
      oerr <= 1'b0;
    end else begin
      last_get <= ch_get;
      ovld <= grant;
      if (grant) begin
        ptr <= int'(win) == NCH - 1 ? '0 : win + 1'b1;
        oinfo <= ch_info[int'(win)*INFO +: INFO];
        ochid <= win;
      end
      if (grant && !icrdret) ocredit <= ocredit - 1'b1;
      else if (!grant && icrdret && !full) ocredit <= ocredit + 1'b1;
      if (!grant && icrdret && full) oerr <= 1'b1;
    end
endmodule
